// File: rtl/alg_amba_vip_base_vldrdy_skid_fifo.sv
// Valid/ready decoupling FIFO for VIP channels: registered in_ready, registered head,
// occupancy level, almost-full flag, synchronous flush, optional wire-through mode.
module alg_amba_vip_base_vldrdy_skid_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int AFULL_THR  = 1,
    parameter int PASSTHRU   = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           almost_full
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (PASSTHRU != 0) begin : gPass

        logic unusedInputs;
        assign unusedInputs = &{1'b0, clk, rstn, flush};

        assign out_valid   = in_valid;
        assign out_data    = in_data;
        assign in_ready    = out_ready;
        assign level       = '0;
        assign almost_full = 1'b0;

    end else begin : gBuf

        localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
        localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AFULL_THR);
        localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [LW-1:0]         level_q, level_d;
        logic                  in_ready_q, in_ready_d;
        logic                  out_valid_q, out_valid_d;
        logic                  afull_q, afull_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic                  push, pop;

        function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
            return (p == LAST_PTR) ? '0 : p + 1'b1;
        endfunction

        assign push = in_valid & in_ready_q;
        assign pop  = out_valid_q & out_ready;

        // The head register preloads whatever entry will sit at rd_ptr after this edge,
        // including a word being written into that very slot this cycle.
        always_comb begin
            rd_ptr_d   = rd_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            level_d    = level_q;
            out_data_d = out_data_q;
            if (flush) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                level_d  = '0;
            end else begin
                if (push) wr_ptr_d = nextPtr(wr_ptr_q);
                if (pop)  rd_ptr_d = nextPtr(rd_ptr_q);
                if (push && !pop)      level_d = level_q + 1'b1;
                else if (pop && !push) level_d = level_q - 1'b1;
                if (level_d != '0)
                    out_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? in_data : mem_q[rd_ptr_d];
            end
            in_ready_d  = (level_d < FULL_LVL);
            out_valid_d = (level_d != '0);
            afull_d     = (level_d >= AF_LVL);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                level_q     <= '0;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b0;
                afull_q     <= 1'b0;
                out_data_q  <= '0;
            end else begin
                rd_ptr_q    <= rd_ptr_d;
                wr_ptr_q    <= wr_ptr_d;
                level_q     <= level_d;
                in_ready_q  <= in_ready_d;
                out_valid_q <= out_valid_d;
                afull_q     <= afull_d;
                out_data_q  <= out_data_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push && !flush) mem_q[wr_ptr_q] <= in_data;
        end

        assign in_ready    = in_ready_q;
        assign out_valid   = out_valid_q;
        assign out_data    = out_data_q;
        assign level       = level_q;
        assign almost_full = afull_q;

        aNoPushWhenFull: assert property (@(posedge clk) disable iff (!rstn)
            !(push && (level_q == FULL_LVL)));
        aLevelBound: assert property (@(posedge clk) disable iff (!rstn)
            level_q <= FULL_LVL);
        aStableStall: assert property (@(posedge clk) disable iff (!rstn)
            (out_valid_q && !out_ready && !flush) |=> $stable(out_data_q));

    end

endmodule
